noc_cmd_sequencer: RTL

Synthesizable, programmable command scheduler for the BFT deflection NoC. It replaces hard-coded per-test stimulus with a loadable table of {delay, command} entries that drives the network's `cmd` bus. It supports one-shot, looped and random-traffic modes, counts cycles, watches `done_all` with a timeout, and reports completion. It sits between a host/bench and the `bft` top's `cmd` and `done_all` ports.

---
 rtl/noc_cmd_pkg.sv | 33 +++
 rtl/noc_cmd_table.sv | 32 +++
 rtl/noc_cmd_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_cmd_pkg.sv
// Shared command codes, mode encodings and sequencer state for the BFT NoC
// command sequencer and the traffic clients that decode its cmd bus.
package noc_cmd_pkg;

  localparam int unsigned NocCmdW = 6;

  localparam logic [NocCmdW-1:0] Cmd_IDLE     = 6'd0;
  localparam logic [NocCmdW-1:0] Cmd_RND      = 6'd1;
  localparam logic [NocCmdW-1:0] Cmd_XY_EAST  = 6'd2;
  localparam logic [NocCmdW-1:0] Cmd_XY_WEST  = 6'd3;
  localparam logic [NocCmdW-1:0] Cmd_XY_NORTH = 6'd4;
  localparam logic [NocCmdW-1:0] Cmd_XY_SOUTH = 6'd5;
  localparam logic [NocCmdW-1:0] Cmd_XY_LOCAL = 6'd6;
  localparam logic [NocCmdW-1:0] Cmd_XY_FAR   = 6'd7;

  localparam logic [1:0] ModeOneshot = 2'b00;
  localparam logic [1:0] ModeLoop    = 2'b01;
  localparam logic [1:0] ModeRnd     = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StDrain,
    StRunRnd,
    StDone
  } seq_state_e;

  // The spare encoding 2'b11 behaves exactly like a one-shot program.
  function automatic logic [1:0] normMode(input logic [1:0] mode);
    return (mode == 2'b11) ? ModeOneshot : mode;
  endfunction

endpackage

// File: rtl/noc_cmd_table.sv
// Program table: DEPTH entries of {delay, command}, one write port and one
// asynchronous read port. Contents survive reset.
module noc_cmd_table #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DLY_W = 16,
  parameter int unsigned CMD_W = 6,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [DLY_W-1:0] wr_delay_i,
  input  logic [CMD_W-1:0] wr_cmd_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [DLY_W-1:0] rd_delay_o,
  output logic [CMD_W-1:0] rd_cmd_o
);

  logic [DLY_W-1:0] delayMem_q [DEPTH];
  logic [CMD_W-1:0] cmdMem_q   [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      delayMem_q[wr_addr_i] <= wr_delay_i;
      cmdMem_q[wr_addr_i]   <= wr_cmd_i;
    end
  end

  assign rd_delay_o = delayMem_q[rd_addr_i];
  assign rd_cmd_o   = cmdMem_q[rd_addr_i];

endmodule

// File: rtl/noc_cmd_sequencer.sv
// Programmable command scheduler driving the BFT NoC cmd bus from a loadable
// {delay, command} table, with one-shot, looped and random-traffic modes.
module noc_cmd_sequencer
  import noc_cmd_pkg::*;
#(
  parameter int unsigned     CMD_W    = 6,
  parameter int unsigned     DEPTH    = 16,
  parameter int unsigned     DLY_W    = 16,
  parameter int unsigned     CNT_W    = 32,
  parameter int unsigned     TIMEOUT  = 0,
  parameter logic [CMD_W-1:0] IDLE_CMD = CMD_W'(Cmd_IDLE),
  parameter logic [CMD_W-1:0] RND_CMD  = CMD_W'(Cmd_RND),
  localparam int unsigned    AW       = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [DLY_W-1:0] wr_delay_i,
  input  logic [CMD_W-1:0] wr_cmd_i,
  input  logic [AW-1:0]    last_idx_i,
  input  logic [1:0]       mode_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             abort_i,
  input  logic             done_all_i,
  output logic [CMD_W-1:0] cmd_o,
  output logic             cmd_valid_o,
  output logic             busy_o,
  output logic             finished_o,
  output logic             timed_out_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [15:0]      loop_count_o
);

  seq_state_e       state_q;
  logic [1:0]       mode_q;
  logic [AW-1:0]    lastIdx_q;
  logic [AW-1:0]    idx_q;
  logic [DLY_W-1:0] dcnt_q;
  logic             fresh_q;
  logic             stopSeen_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmdValid_q;
  logic             finished_q;
  logic             timedOut_q;
  logic [CNT_W-1:0] cycleCnt_q;
  logic [15:0]      loopCnt_q;

  logic             busy;
  logic             tableWe;
  logic [DLY_W-1:0] entryDelay;
  logic [CMD_W-1:0] entryCmd;
  logic [DLY_W-1:0] effDelay;
  logic [CNT_W-1:0] cycleCntNext;
  logic             timeoutHit;
  logic             doneFinish;

  assign busy    = (state_q != StIdle) && (state_q != StDone);
  assign tableWe = ce_i && wr_en_i && !busy && !start_i;

  noc_cmd_table #(
    .DEPTH (DEPTH),
    .DLY_W (DLY_W),
    .CMD_W (CMD_W)
  ) u_table (
    .clk_i      (clk_i),
    .wr_en_i    (tableWe),
    .wr_addr_i  (wr_addr_i),
    .wr_delay_i (wr_delay_i),
    .wr_cmd_i   (wr_cmd_i),
    .rd_addr_i  (idx_q),
    .rd_delay_o (entryDelay),
    .rd_cmd_o   (entryCmd)
  );

  // A freshly selected entry has not loaded its delay yet, so the table value
  // is used directly; this keeps delay-0 entries back-to-back on one read port.
  assign effDelay     = fresh_q ? entryDelay : dcnt_q;
  assign cycleCntNext = cycleCnt_q + CNT_W'(1);
  assign timeoutHit   = (TIMEOUT != 0) && (cycleCntNext == CNT_W'(TIMEOUT));
  assign doneFinish   = done_all_i && ((state_q == StDrain) || (state_q == StRunRnd));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= ModeOneshot;
      lastIdx_q  <= '0;
      idx_q      <= '0;
      dcnt_q     <= '0;
      fresh_q    <= 1'b0;
      stopSeen_q <= 1'b0;
      cmd_q      <= IDLE_CMD;
      cmdValid_q <= 1'b0;
      finished_q <= 1'b0;
      timedOut_q <= 1'b0;
      cycleCnt_q <= '0;
      loopCnt_q  <= '0;
    end else if (abort_i) begin
      state_q    <= StIdle;
      cmd_q      <= IDLE_CMD;
      cmdValid_q <= 1'b0;
    end else if (!ce_i) begin
      cmd_q      <= IDLE_CMD;
      cmdValid_q <= 1'b0;
    end else begin
      cmd_q      <= IDLE_CMD;
      cmdValid_q <= 1'b0;
      if (busy) cycleCnt_q <= cycleCntNext;

      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            mode_q     <= normMode(mode_i);
            lastIdx_q  <= last_idx_i;
            idx_q      <= '0;
            fresh_q    <= 1'b1;
            stopSeen_q <= 1'b0;
            cycleCnt_q <= '0;
            loopCnt_q  <= '0;
            finished_q <= 1'b0;
            timedOut_q <= 1'b0;
            if (normMode(mode_i) == ModeRnd) begin
              state_q    <= StRunRnd;
              cmd_q      <= RND_CMD;
              cmdValid_q <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end
        end

        StWait: begin
          fresh_q <= 1'b0;
          if (stop_i) stopSeen_q <= 1'b1;
          if (effDelay != '0) begin
            dcnt_q <= effDelay - DLY_W'(1);
          end else begin
            cmd_q      <= entryCmd;
            cmdValid_q <= 1'b1;
            if (idx_q < lastIdx_q) begin
              idx_q   <= idx_q + AW'(1);
              fresh_q <= 1'b1;
            end else if (mode_q == ModeLoop) begin
              if (loopCnt_q != 16'hFFFF) loopCnt_q <= loopCnt_q + 16'd1;
              if (stopSeen_q || stop_i) begin
                state_q <= StDrain;
              end else begin
                idx_q      <= '0;
                fresh_q    <= 1'b1;
                stopSeen_q <= 1'b0;
              end
            end else begin
              state_q <= StDrain;
            end
          end
        end

        StRunRnd: begin
          if (done_all_i) begin
            state_q    <= StDone;
            finished_q <= 1'b1;
          end else if (stop_i) begin
            state_q <= StDrain;
          end else begin
            cmd_q      <= RND_CMD;
            cmdValid_q <= 1'b1;
          end
        end

        StDrain: begin
          if (done_all_i) begin
            state_q    <= StDone;
            finished_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase

      // A completion seen on the same edge as the timeout is reported as finished.
      if (busy && timeoutHit && !doneFinish) begin
        state_q    <= StDone;
        timedOut_q <= 1'b1;
        cmd_q      <= IDLE_CMD;
        cmdValid_q <= 1'b0;
      end
    end
  end

  assign cmd_o         = cmd_q;
  assign cmd_valid_o   = cmdValid_q;
  assign busy_o        = busy;
  assign finished_o    = finished_q;
  assign timed_out_o   = timedOut_q;
  assign cycle_count_o = cycleCnt_q;
  assign loop_count_o  = loopCnt_q;

endmodule
